fetch_ctrl: RTL and testbench

//  Instruction-fetch controller that drives the PC register and the instruction-memory port.
//  - Issues one outstanding imem request at the current pc.
//  - Computes pc_next and the pc load enable (pc_en: 0 = load pc_next, 1 = hold).
//  - Delivers fetched instructions to decode over a valid/stall interface.
//  - Handles branch redirects and discards stale in-flight responses.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_buf.sv | 32 +++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Fetch controller shared types: FSM state encoding and default pc step.
// No ports; imported by fetch_ctrl and fetch_buf.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } fstate_t;

  localparam int PC_STEP_DEF = 4;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a response decode could not take yet.
// Ports: clk, rst (async low), load/drain/flush, d in, full/q out.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: pc sequencing, imem port, decode handoff.
// Ports: pc/pc_next/pc_en, redirect, imem req/gnt/rvalid, if_* to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int ILEN    = 32,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] pc,
  output logic [SIZE-1:0] pc_next,
  output logic            pc_en,
  input  logic            redirect,
  input  logic [SIZE-1:0] redirect_pc,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [SIZE-1:0] if_pc,
  input  logic            id_stall
);

  fstate_t         state, state_d;
  logic            kill, kill_d;
  logic            slot_free;
  logic            deliver;
  logic            drain_buf;
  logic            buf_load;
  logic            buf_flush;
  logic            buf_full;
  logic [ILEN-1:0] buf_q;

  assign slot_free = !if_valid || !id_stall;
  assign imem_addr = pc;
  assign pc_next   = redirect ? redirect_pc
                              : pc + SIZE'(PC_STEP);
  // pc only advances when an instruction
  // actually lands in if_*, or on redirect
  assign pc_en = !(redirect || deliver || drain_buf);

  always_comb begin
    state_d   = state;
    kill_d    = kill;
    imem_req  = 1'b0;
    deliver   = 1'b0;
    drain_buf = 1'b0;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    unique case (state)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
          // granted address is now stale
          if (redirect) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
          if (kill) kill_d = 1'b0;
          else if (slot_free) deliver = 1'b1;
          else begin
            buf_load = 1'b1;
            state_d  = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          buf_flush = 1'b1;
          state_d   = S_REQ;
        end else if (slot_free && buf_full) begin
          drain_buf = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_BOOT;
      kill  <= 1'b0;
    end else begin
      state <= state_d;
      kill  <= kill_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (deliver) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (drain_buf) begin
      if_valid <= 1'b1;
      if_instr <= buf_q;
      if_pc    <= pc;
    end else if (if_valid && !id_stall) begin
      if_valid <= 1'b0;
    end
  end

  fetch_buf #(
    .W(ILEN)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (buf_load),
    .drain(drain_buf),
    .flush(buf_flush),
    .d    (imem_rdata),
    .full (buf_full),
    .q    (buf_q)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, directed
// sequences, then randomized traffic against a stream scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;

  int checks = 0;
  int errors = 0;

  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          mem_delay = 1;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_next    (pc_next),
    .pc_en      (pc_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_stall   (id_stall)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 8) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // PC register + memory model advance one clock
  task automatic step();
    logic        en;
    logic [31:0] nx;
    en = pc_en;
    nx = pc_next;
    if (imem_rvalid) pend = 1'b0;
    if (rst && imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = mem_delay;
    end
    @(posedge clk);
    #1;
    if (!rst) pc = '0;
    else if (!en) pc = nx;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend_addr);
      end
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] nxt;
    logic        en;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] exp_pc;
    logic        p_redir;
    logic        p_hold;
    logic [31:0] p_pc;
    logic [31:0] p_instr;
    int          accepted;

    rst = 1'b0; pc = '0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0;

    tbl[0] = '{32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b1};
    tbl[1] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0000_0000, 1'b1};
    tbl[2] = '{32'h0000_0100, 1'b1, 32'h40, 32'h0000_0040, 1'b0};
    tbl[3] = '{32'h7FFF_FFFC, 1'b0, 32'h0, 32'h8000_0000, 1'b1};
    tbl[4] = '{32'h0000_1234, 1'b1, 32'hFFFF_FFFC,
               32'hFFFF_FFFC, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0000_0000, 1'b0};

    #2;
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b1);

    for (int i = 0; i < 6; i++) begin
      pc = tbl[i].pc;
      redirect = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk("tbl_pc_next", pc_next, tbl[i].nxt);
      chk1("tbl_pc_en", pc_en, tbl[i].en);
      chk("tbl_addr", imem_addr, tbl[i].pc);
      chk1("tbl_req", imem_req, 1'b0);
    end
    pc = '0; redirect = 1'b0; redirect_pc = '0;

    // 1: zero-wait sequential fetch
    mem_delay = 1; imem_gnt = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk1("boot_req", imem_req, 1'b0);
    chk1("boot_pc_en", pc_en, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk1("t1_en_req", pc_en, 1'b1);
      if (k > 0) begin
        chk1("t1_if_valid", if_valid, 1'b1);
        chk("t1_if_pc", if_pc, 32'(4 * (k - 1)));
        chk("t1_if_instr", if_instr, mem(32'(4 * (k - 1))));
      end
      step();
      @(negedge clk);
      chk1("t1_en_rvalid", pc_en, 1'b0);
      step();
    end

    // 2: decode stall fills the buffer
    id_stall = 1'b1;
    @(negedge clk);
    chk("t1_last_pc", if_pc, 32'h8);
    chk("t1_last_instr", if_instr, 32'h0000_0813);
    step();
    @(negedge clk);
    chk1("t2_en_wait", pc_en, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t2_full_req", imem_req, 1'b0);
      chk1("t2_full_en", pc_en, 1'b1);
      chk1("t2_full_valid", if_valid, 1'b1);
      chk("t2_full_if_pc", if_pc, 32'h8);
      step();
    end
    id_stall = 1'b0;
    @(negedge clk);
    chk1("t2_drain_en", pc_en, 1'b0);
    step();
    @(negedge clk);
    chk("t2_buf_pc", if_pc, 32'hC);
    chk("t2_buf_instr", if_instr, mem(32'hC));
    chk("t2_pc_adv", pc, 32'h10);
    chk("t2_next_addr", imem_addr, 32'h10);

    // 3: redirect in S_WAIT, stale response 2 cycles later
    mem_delay = 3;
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk1("t3_en", pc_en, 1'b0);
    chk("t3_pc_next", pc_next, 32'h100);
    step();
    @(negedge clk);
    chk1("t3_valid_clr", if_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t3_stale_en", pc_en, 1'b1);
    step();
    @(negedge clk);
    chk1("t3_req", imem_req, 1'b1);
    chk("t3_addr", imem_addr, 32'h100);
    chk1("t3_no_stale", if_valid, 1'b0);
    mem_delay = 1;
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk1("t3_valid", if_valid, 1'b1);
    chk("t3_if_pc", if_pc, 32'h100);
    chk("t3_if_instr", if_instr, mem(32'h100));

    // 4: redirect coincident with rvalid
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk1("t4_en", pc_en, 1'b0);
    step();
    @(negedge clk);
    chk1("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 32'h100);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk1("t4_valid", if_valid, 1'b1);
    chk("t4_if_pc", if_pc, 32'h100);
    chk("t4_if_instr", if_instr, mem(32'h100));

    // 6: reset during S_WAIT, response lands after release
    mem_delay = 2;
    step();
    rst = 1'b0; pc = '0;
    @(negedge clk);
    chk1("t6_rst_req", imem_req, 1'b0);
    chk1("t6_rst_valid", if_valid, 1'b0);
    chk1("t6_rst_en", pc_en, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk1("t6_boot_req", imem_req, 1'b0);
    chk1("t6_boot_valid", if_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, 32'h0);
    chk1("t6_ignored", if_valid, 1'b0);

    // random traffic against an in-order stream scoreboard
    exp_pc = '0; p_redir = 1'b0; p_hold = 1'b0;
    p_pc = '0; p_instr = '0; accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      id_stall  = ($urandom_range(0, 2) == 0);
      imem_gnt  = ($urandom_range(0, 3) != 0);
      mem_delay = $urandom_range(1, 3);
      redirect  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0;
      else redirect_pc = $urandom & 32'h00FF_FFFC;
      @(negedge clk);
      chk("r_addr", imem_addr, pc);
      chk("r_pc_next", pc_next,
          redirect ? redirect_pc : pc + 32'd4);
      if (redirect) chk1("r_redir_en", pc_en, 1'b0);
      if (pend) chk1("r_one_outst", imem_req, 1'b0);
      if (p_redir) chk1("r_flush", if_valid, 1'b0);
      if (p_hold) begin
        chk1("r_hold_v", if_valid, 1'b1);
        chk("r_hold_pc", if_pc, p_pc);
        chk("r_hold_instr", if_instr, p_instr);
      end
      if (if_valid && !id_stall) begin
        chk("r_stream_pc", if_pc, exp_pc);
        chk("r_stream_instr", if_instr, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (redirect) exp_pc = redirect_pc;
      p_redir = redirect;
      p_hold  = if_valid && id_stall && !redirect;
      p_pc    = if_pc;
      p_instr = if_instr;
    end
    checks++;
    if (accepted < 100) begin
      errors++;
      $display("FAIL r_progress: got %0d accepted want >= 100",
               accepted);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
